// File: rtl/riscv_pkg.sv
// RV32I decode types shared by decode, control and execute: opcodes, operation
// classes, ALU ops, immediate formats and the decoded bundle.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
        CLS_STORE, CLS_OPIMM, CLS_OP, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL
    } op_class_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        op_class_e   op_class;
        alu_op_e     alu_op;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } dec_bundle_t;

    typedef struct packed {
        logic [31:0] pc;
        dec_bundle_t dec;
    } stage_entry_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // alt selects SUB for funct3=0 and SRA for funct3=5
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Pure combinational RV32I decoder: raw instruction word -> decoded bundle.
// Illegal encodings collapse to an all-zero bundle tagged CLS_ILLEGAL.
import riscv_pkg::*;

module decode_comb (
    input  logic [31:0] instr_i,
    output dec_bundle_t bundle_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    op_class_e  cls;
    alu_op_e    alu;
    imm_fmt_e   fmt;
    logic       has_rd;
    logic       use1;
    logic       use2;
    logic       bad;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        cls    = CLS_ILLEGAL;
        alu    = ALU_ADD;
        fmt    = IMM_NONE;
        has_rd = 1'b0;
        use1   = 1'b0;
        use2   = 1'b0;
        bad    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                cls = CLS_LUI; alu = ALU_PASSB; fmt = IMM_U; has_rd = 1'b1;
            end
            OPC_AUIPC: begin
                cls = CLS_AUIPC; fmt = IMM_U; has_rd = 1'b1;
            end
            OPC_JAL: begin
                cls = CLS_JAL; fmt = IMM_J; has_rd = 1'b1;
            end
            OPC_JALR: begin
                cls = CLS_JALR; fmt = IMM_I; has_rd = 1'b1; use1 = 1'b1;
            end
            OPC_BRANCH: begin
                cls = CLS_BRANCH; fmt = IMM_B; use1 = 1'b1; use2 = 1'b1;
                bad = (funct3[2:1] == 2'b01);
                // equality compares via SUB, ordered compares via SLT/SLTU
                case (funct3[2:1])
                    2'b10:   alu = ALU_SLT;
                    2'b11:   alu = ALU_SLTU;
                    default: alu = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                cls = CLS_LOAD; fmt = IMM_I; has_rd = 1'b1; use1 = 1'b1;
                bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                cls = CLS_STORE; fmt = IMM_S; use1 = 1'b1; use2 = 1'b1;
                bad = (funct3 > 3'd2);
            end
            OPC_OPIMM: begin
                cls = CLS_OPIMM; fmt = IMM_I; has_rd = 1'b1; use1 = 1'b1;
                alu = alu_from_funct3(funct3, (funct3 == 3'd5) && instr_i[30]);
                if (funct3 == 3'd1)
                    bad = (funct7 != F7_BASE);
                else if (funct3 == 3'd5)
                    bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            end
            OPC_OP: begin
                cls = CLS_OP; has_rd = 1'b1; use1 = 1'b1; use2 = 1'b1;
                alu = alu_from_funct3(funct3, funct7 == F7_ALT);
                if (funct7 == F7_ALT)
                    bad = (funct3 != 3'd0) && (funct3 != 3'd5);
                else if (funct7 != F7_BASE)
                    bad = 1'b1;
            end
            OPC_FENCE: begin
                cls = CLS_FENCE;
            end
            OPC_SYSTEM: begin
                cls = CLS_SYSTEM; fmt = IMM_I; has_rd = 1'b1; use1 = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11)
            bad = 1'b1;

        bundle_o = '0;
        if (bad) begin
            bundle_o.op_class = CLS_ILLEGAL;
            bundle_o.illegal  = 1'b1;
        end else begin
            bundle_o.op_class  = cls;
            bundle_o.alu_op    = alu;
            bundle_o.funct3    = funct3;
            bundle_o.rd        = has_rd ? instr_i[11:7] : 5'd0;
            bundle_o.rs1       = use1 ? instr_i[19:15] : 5'd0;
            bundle_o.rs2       = use2 ? instr_i[24:20] : 5'd0;
            bundle_o.imm       = gen_imm(instr_i, fmt);
            bundle_o.uses_rs1  = use1;
            bundle_o.uses_rs2  = use2;
            bundle_o.writes_rd = has_rd && (instr_i[11:7] != 5'd0);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched word combinationally and holds it in a
// two-entry skid buffer (or a single register) behind valid/ready handshakes.
import riscv_pkg::*;

module decode_stage #(
    parameter bit SKID_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] dec_pc_o,
    output logic [3:0]  op_class_o,
    output logic [3:0]  alu_op_o,
    output logic [2:0]  funct3_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o,
    output logic        writes_rd_o,
    output logic        illegal_o
);

    typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} buf_state_e;

    buf_state_e   state_q, state_d;
    stage_entry_t main_q, main_d;
    stage_entry_t skid_q, skid_d;
    stage_entry_t in_entry;
    dec_bundle_t  in_dec;
    logic         valid_q;
    logic         ready_q;
    logic         enq;
    logic         deq;

    decode_comb u_decode_comb (
        .instr_i  (instr_i),
        .bundle_o (in_dec)
    );

    assign in_entry.pc  = pc_i;
    assign in_entry.dec = in_dec;

    // Without the skid entry, ready must see the downstream consume in the same cycle
    assign fetch_ready_o = SKID_EN ? ready_q : (dec_ready_i | ~valid_q);
    assign dec_valid_o   = valid_q;

    assign enq = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign deq = valid_q & dec_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (enq) begin
                        main_d  = in_entry;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    case ({enq, deq})
                        2'b11: main_d = in_entry;
                        2'b01: state_d = BUF_EMPTY;
                        2'b10: begin
                            skid_d  = in_entry;
                            state_d = BUF_TWO;
                        end
                        default: ;
                    endcase
                end
                BUF_TWO: begin
                    if (deq) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= (state_d != BUF_EMPTY);
            ready_q <= (state_d != BUF_TWO);
        end
    end

    assign dec_pc_o    = main_q.pc;
    assign op_class_o  = main_q.dec.op_class;
    assign alu_op_o    = main_q.dec.alu_op;
    assign funct3_o    = main_q.dec.funct3;
    assign rd_o        = main_q.dec.rd;
    assign rs1_o       = main_q.dec.rs1;
    assign rs2_o       = main_q.dec.rs2;
    assign imm_o       = main_q.dec.imm;
    assign uses_rs1_o  = main_q.dec.uses_rs1;
    assign uses_rs2_o  = main_q.dec.uses_rs2;
    assign writes_rd_o = main_q.dec.writes_rd;
    assign illegal_o   = main_q.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-decoded vectors are queued on fetch
// acceptance and compared field by field when the stage hands them downstream.
import riscv_pkg::*;

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush_i = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic        dec_valid_o;
    logic        dec_ready_i = 1'b0;
    logic [31:0] dec_pc_o;
    logic [3:0]  op_class_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  funct3_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [31:0] imm_o;
    logic        uses_rs1_o, uses_rs2_o, writes_rd_o, illegal_o;

    decode_stage #(.SKID_EN(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .pc_i          (pc_i),
        .instr_i       (instr_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .op_class_o    (op_class_o),
        .alu_op_o      (alu_op_o),
        .funct3_o      (funct3_o),
        .rd_o          (rd_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .imm_o         (imm_o),
        .uses_rs1_o    (uses_rs1_o),
        .uses_rs2_o    (uses_rs2_o),
        .writes_rd_o   (writes_rd_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        u1, u2, wr, ill;
    } vec_t;

    vec_t tab[13];
    vec_t sb[$];
    vec_t cur;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int idx, input logic [31:0] instr, input logic [3:0] cls,
                                input logic [3:0] alu, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                                input logic u1, input logic u2, input logic wr, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = 32'h1000 + 32'(idx * 4);
        v.cls = cls; v.alu = alu; v.f3 = f3; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.u1 = u1; v.u2 = u2; v.wr = wr; v.ill = ill;
        return v;
    endfunction

    // Output side pops and compares; input side pushes on each accepted transfer
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
        end else begin
            if (dec_valid_o && dec_ready_i) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", sb.size(), 1);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    check_val("pc",       dec_pc_o,    e.pc);
                    check_val("op_class", op_class_o,  e.cls);
                    check_val("alu_op",   alu_op_o,    e.alu);
                    check_val("funct3",   funct3_o,    e.f3);
                    check_val("rd",       rd_o,        e.rd);
                    check_val("rs1",      rs1_o,       e.rs1);
                    check_val("rs2",      rs2_o,       e.rs2);
                    check_val("imm",      imm_o,       e.imm);
                    check_val("uses_rs1", uses_rs1_o,  e.u1);
                    check_val("uses_rs2", uses_rs2_o,  e.u2);
                    check_val("writes_rd",writes_rd_o, e.wr);
                    check_val("illegal",  illegal_o,   e.ill);
                end
            end
            if (flush_i)
                sb.delete();
            else if (fetch_valid_i && fetch_ready_o)
                sb.push_back(cur);
        end
    end

    task automatic drive(input vec_t v);
        cur = v;
        fetch_valid_i = 1'b1;
        pc_i = v.pc;
        instr_i = v.instr;
    endtask

    // stall>0: hold dec_ready low that many cycles; stall<0: random dec_ready
    task automatic stream(input int first, input int n, input int stall);
        int sent = 0;
        int cyc = 0;
        int run = 0;
        bit gap = 1'b0;
        bit released;
        bit acc;
        released = (stall <= 0);
        dec_ready_i = (stall == 0) ? 1'b1 : 1'b0;
        while ((sent < n || sb.size() != 0 || dec_valid_o) && cyc < 300) begin
            if (stall < 0)
                dec_ready_i = 1'($urandom_range(0, 1));
            if (sent < n)
                drive(tab[first + sent]);
            else
                fetch_valid_i = 1'b0;
            @(negedge clk);
            acc = fetch_valid_i && fetch_ready_o;
            if (released && stall > 0) begin
                if (dec_valid_o && !gap) run++;
                else gap = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
            if (!released && cyc == stall) begin
                check_val("stall_accepts", sent, 2);
                check_val("stall_ready", fetch_ready_o, 0);
                dec_ready_i = 1'b1;
                released = 1'b1;
            end
        end
        fetch_valid_i = 1'b0;
        check_val("stream_sent", sent, n);
        check_val("stream_drained", sb.size(), 0);
        if (stall > 0)
            check_val("no_gap_run", run, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tab[0]  = mk(0,  32'h00500093, CLS_OPIMM,   ALU_ADD,   3'd0, 5'd1,  5'd0, 5'd0, 32'h00000005, 1, 0, 1, 0);
        tab[1]  = mk(1,  32'hFE20AE23, CLS_STORE,   ALU_ADD,   3'd2, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFC, 1, 1, 0, 0);
        tab[2]  = mk(2,  32'hFE000EE3, CLS_BRANCH,  ALU_SUB,   3'd0, 5'd0,  5'd0, 5'd0, 32'hFFFFFFFC, 1, 1, 0, 0);
        tab[3]  = mk(3,  32'h00000000, CLS_ILLEGAL, ALU_ADD,   3'd0, 5'd0,  5'd0, 5'd0, 32'h00000000, 0, 0, 0, 1);
        tab[4]  = mk(4,  32'h123452B7, CLS_LUI,     ALU_PASSB, 3'd5, 5'd5,  5'd0, 5'd0, 32'h12345000, 0, 0, 1, 0);
        tab[5]  = mk(5,  32'hFF9FF0EF, CLS_JAL,     ALU_ADD,   3'd7, 5'd1,  5'd0, 5'd0, 32'hFFFFFFF8, 0, 0, 1, 0);
        tab[6]  = mk(6,  32'h402081B3, CLS_OP,      ALU_SUB,   3'd0, 5'd3,  5'd1, 5'd2, 32'h00000000, 1, 1, 1, 0);
        tab[7]  = mk(7,  32'h40209233, CLS_ILLEGAL, ALU_ADD,   3'd0, 5'd0,  5'd0, 5'd0, 32'h00000000, 0, 0, 0, 1);
        tab[8]  = mk(8,  32'h4033D393, CLS_OPIMM,   ALU_SRA,   3'd5, 5'd7,  5'd7, 5'd0, 32'h00000403, 1, 0, 1, 0);
        tab[9]  = mk(9,  32'h0000B083, CLS_ILLEGAL, ALU_ADD,   3'd0, 5'd0,  5'd0, 5'd0, 32'h00000000, 0, 0, 0, 1);
        tab[10] = mk(10, 32'h00000013, CLS_OPIMM,   ALU_ADD,   3'd0, 5'd0,  5'd0, 5'd0, 32'h00000000, 1, 0, 0, 0);
        tab[11] = mk(11, 32'h00500091, CLS_ILLEGAL, ALU_ADD,   3'd0, 5'd0,  5'd0, 5'd0, 32'h00000000, 0, 0, 0, 1);
        tab[12] = mk(12, 32'h00812503, CLS_LOAD,    ALU_ADD,   3'd2, 5'd10, 5'd2, 5'd0, 32'h00000008, 1, 0, 1, 0);
        cur = tab[0];

        // Reset state
        #1;
        check_val("rst_valid", dec_valid_o, 0);
        check_val("rst_pc", dec_pc_o, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rst_rel_ready", fetch_ready_o, 1);
        check_val("rst_rel_valid", dec_valid_o, 0);

        // Directed decodes, free-flowing downstream
        stream(0, 4, 0);
        stream(4, 9, 0);
        // Backpressure: two accepted, then gap-free release
        stream(4, 4, 6);
        // Random downstream stalls over the whole table
        stream(0, 13, -1);

        // Flush while both entries are full, with a fetch offered the same cycle
        dec_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(tab[i]);
            @(posedge clk); #1;
        end
        check_val("pre_flush_ready", fetch_ready_o, 0);
        drive(tab[2]);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        fetch_valid_i = 1'b0;
        check_val("flush_valid", dec_valid_o, 0);
        check_val("flush_ready", fetch_ready_o, 1);
        dec_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("flush_quiet", dec_valid_o, 0);
        stream(6, 1, 0);

        // Asynchronous reset between edges with the buffer full
        dec_ready_i = 1'b0;
        for (int i = 4; i < 6; i++) begin
            drive(tab[i]);
            @(posedge clk); #1;
        end
        fetch_valid_i = 1'b0;
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        check_val("arst_valid", dec_valid_o, 0);
        check_val("arst_pc", dec_pc_o, 0);
        check_val("arst_imm", imm_o, 0);
        check_val("arst_class", op_class_o, 0);
        check_val("arst_rd", rd_o, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("arst_rel_ready", fetch_ready_o, 1);
        check_val("arst_rel_valid", dec_valid_o, 0);
        stream(12, 1, 0);

        check_val("sb_final", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
